// File: rtl/network_sequencer_if.sv
// Bus between a host, the network_sequencer and the stochastic network it drives.
// The slave modport is the sequencer's view; the master modport is the host plus network.
interface network_sequencer_if #(
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 1
);
  logic start;
  logic abort;
  int   in_data    [0:INPUT_SIZE-1];
  int   net_input  [0:INPUT_SIZE-1];
  logic net_n_rst;
  logic net_compute;
  int   net_output [0:OUTPUT_SIZE-1];
  logic busy;
  logic done;
  int   result     [0:OUTPUT_SIZE-1];
  logic result_valid;

  modport slave (
    input  start, abort, in_data, net_output,
    output net_input, net_n_rst, net_compute, busy, done, result, result_valid
  );

  modport master (
    output start, abort, in_data, net_output,
    input  net_input, net_n_rst, net_compute, busy, done, result, result_valid
  );
endinterface

// File: rtl/network_sequencer.sv
// Sequences one bitstream inference: clear the network, let its pipeline settle,
// stream for STREAM_LEN cycles, strobe the integrators, then latch their result.
module network_sequencer #(
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 1,
  parameter int STREAM_LEN  = 256,
  parameter int SETTLE_LEN  = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  network_sequencer_if.slave  bus
);

  localparam int RUN_W    = $clog2(STREAM_LEN + 1);
  localparam int SETTLE_W = 8;

  localparam logic [RUN_W-1:0]    RUN_LOAD    = RUN_W'(STREAM_LEN - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_LEN > 0 ? SETTLE_LEN - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    RUN,
    CAPTURE,
    LATCH
  } state_e;

  state_e                state_q,        state_d;
  logic [RUN_W-1:0]      run_cnt_q,      run_cnt_d;
  logic [SETTLE_W-1:0]   settle_cnt_q,   settle_cnt_d;
  int                    net_input_q     [0:INPUT_SIZE-1];
  int                    net_input_d     [0:INPUT_SIZE-1];
  int                    result_q        [0:OUTPUT_SIZE-1];
  int                    result_d        [0:OUTPUT_SIZE-1];
  logic                  result_valid_q, result_valid_d;
  logic                  done_q,         done_d;
  logic                  busy_q,         busy_d;
  logic                  net_compute_q,  net_compute_d;
  logic                  net_n_rst_q,    net_n_rst_d;

  always_comb begin
    // NOTE: every _d takes its hold value first so no path through the case infers a latch.
    state_d        = state_q;
    run_cnt_d      = run_cnt_q;
    settle_cnt_d   = settle_cnt_q;
    net_input_d    = net_input_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    done_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d        = CLEAR;
          net_input_d    = bus.in_data;
          result_valid_d = 1'b0;
        end
      end

      CLEAR: begin
        if (SETTLE_LEN == 0) begin
          state_d   = RUN;
          run_cnt_d = RUN_LOAD;
        end else begin
          state_d      = SETTLE;
          settle_cnt_d = SETTLE_LOAD;
        end
      end

      SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d   = RUN;
          run_cnt_d = RUN_LOAD;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end

      // The counter stops at zero and hands over to CAPTURE rather than wrapping.
      RUN: begin
        if (run_cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          run_cnt_d = run_cnt_q - RUN_W'(1);
        end
      end

      CAPTURE: state_d = LATCH;

      LATCH: begin
        state_d        = IDLE;
        result_d       = bus.net_output;
        result_valid_d = 1'b1;
        done_d         = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    // Abort overrides everything above, including a result about to be latched.
    if (bus.abort && (state_q != IDLE)) begin
      state_d        = IDLE;
      result_d       = result_q;
      result_valid_d = 1'b0;
      done_d         = 1'b0;
    end

    // Strobes are decoded from the next state so they leave a flop cleanly.
    busy_d        = (state_d != IDLE);
    net_compute_d = (state_d == CAPTURE);
    net_n_rst_d   = (state_d != CLEAR);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      run_cnt_q      <= '0;
      settle_cnt_q   <= '0;
      // NOTE: these arrays are a handful of operand/result registers, not a RAM,
      // so they take the asynchronous reset like any other flop.
      net_input_q    <= '{default: 0};
      result_q       <= '{default: 0};
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      net_compute_q  <= 1'b0;
      net_n_rst_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_cnt_q      <= run_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      net_input_q    <= net_input_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      net_compute_q  <= net_compute_d;
      net_n_rst_q    <= net_n_rst_d;
    end
  end

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_net_input
    assign bus.net_input[i] = net_input_q[i];
  end

  for (genvar i = 0; i < OUTPUT_SIZE; i++) begin : g_result
    assign bus.result[i] = result_q[i];
  end

  assign bus.result_valid = result_valid_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;
  assign bus.net_compute  = net_compute_q;
  assign bus.net_n_rst    = net_n_rst_q;

endmodule

// File: tb/tb_network_sequencer.sv
// Drives a default-sized and a minimal (STREAM_LEN=1, SETTLE_LEN=0) sequencer from the
// same stimulus and compares both against a cycle-count model of an inference.
module tb_network_sequencer;

  localparam int IN_N  = 2;
  localparam int OUT_N = 1;
  localparam int S_A = 2, L_A = 256;
  localparam int S_B = 0, L_B = 1;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   in_data    [0:IN_N-1];
  int   net_output [0:OUT_N-1];

  always #5 clk = ~clk;

  network_sequencer_if #(.INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N)) bus_a ();
  network_sequencer_if #(.INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N)) bus_b ();

  assign bus_a.start = start;
  assign bus_a.abort = abort;
  assign bus_b.start = start;
  assign bus_b.abort = abort;
  for (genvar i = 0; i < IN_N; i++) begin : g_in
    assign bus_a.in_data[i] = in_data[i];
    assign bus_b.in_data[i] = in_data[i];
  end
  for (genvar i = 0; i < OUT_N; i++) begin : g_out
    assign bus_a.net_output[i] = net_output[i];
    assign bus_b.net_output[i] = net_output[i];
  end

  network_sequencer #(
    .INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N), .STREAM_LEN(L_A), .SETTLE_LEN(S_A)
  ) dut_a (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_a.slave)
  );

  network_sequencer #(
    .INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N), .STREAM_LEN(L_B), .SETTLE_LEN(S_B)
  ) dut_b (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_b.slave)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt_a = 0;

  task automatic check(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, actual, expected);
    end
  endtask

  // Reference model: an inference is a count of edges since acceptance. CLEAR is edge 0,
  // the compute strobe sits at S+L+1 and done at S+L+3.
  int  s_len [2] = '{S_A, S_B};
  int  l_len [2] = '{L_A, L_B};
  bit  m_active [2];
  int  m_k      [2];
  bit  m_rv     [2];
  bit  m_done   [2];
  bit  m_pend   [2];
  int  m_res    [2];
  int  m_in     [2][0:IN_N-1];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_k[d]      = 0;
      m_rv[d]     = 1'b0;
      m_done[d]   = 1'b0;
      m_pend[d]   = 1'b1;
      m_res[d]    = 0;
      for (int i = 0; i < IN_N; i++) m_in[d][i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 1'b0;
      if (n_rst) begin
        m_pend[d] = 1'b0;
        if (m_active[d]) begin
          if (abort) begin
            m_active[d] = 1'b0;
            m_rv[d]     = 1'b0;
          end else begin
            m_k[d]++;
            if (m_k[d] == s_len[d] + l_len[d] + 3) begin
              m_active[d] = 1'b0;
              m_rv[d]     = 1'b1;
              m_res[d]    = net_output[0];
              m_done[d]   = 1'b1;
            end
          end
        end else if (start && !abort) begin
          m_active[d] = 1'b1;
          m_k[d]      = 0;
          m_rv[d]     = 1'b0;
          for (int i = 0; i < IN_N; i++) m_in[d][i] = in_data[i];
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic  o_busy, o_done, o_nr, o_nc, o_rv;
      int    o_res;
      int    o_in [0:IN_N-1];
      string p;
      if (d == 0) begin
        p = "a"; o_busy = bus_a.busy; o_done = bus_a.done; o_nr = bus_a.net_n_rst;
        o_nc = bus_a.net_compute; o_rv = bus_a.result_valid; o_res = bus_a.result[0];
        for (int i = 0; i < IN_N; i++) o_in[i] = bus_a.net_input[i];
      end else begin
        p = "b"; o_busy = bus_b.busy; o_done = bus_b.done; o_nr = bus_b.net_n_rst;
        o_nc = bus_b.net_compute; o_rv = bus_b.result_valid; o_res = bus_b.result[0];
        for (int i = 0; i < IN_N; i++) o_in[i] = bus_b.net_input[i];
      end
      check({p, ".busy"},         o_busy, m_active[d]);
      check({p, ".done"},         o_done, m_done[d]);
      check({p, ".net_n_rst"},    o_nr,   !m_pend[d] && !(m_active[d] && m_k[d] == 0));
      check({p, ".net_compute"},  o_nc,   m_active[d] && m_k[d] == s_len[d] + l_len[d] + 1);
      check({p, ".result_valid"}, o_rv,   m_rv[d]);
      check({p, ".result"},       o_res,  m_res[d]);
      for (int i = 0; i < IN_N; i++)
        check($sformatf("%s.net_input%0d", p, i), o_in[i], m_in[d][i]);
    end
  endtask

  // One clock: sample just after the edge, advance the model, compare, then the
  // network output changes for the next edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    if (bus_a.done) done_cnt_a++;
    net_output[0] = int'($urandom);
  endtask

  // Called just after an edge: reset lands mid-cycle and is checked before any edge.
  task automatic do_reset();
    #2 n_rst = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) cycle();
    #3 n_rst = 1'b1;
    cycle();
  endtask

  initial begin
    for (int i = 0; i < IN_N; i++) in_data[i] = 0;
    net_output[0] = 0;

    #1 n_rst = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) cycle();
    #3 n_rst = 1'b1;
    cycle();

    // Nominal inference with busy-time start pulses and toggling operands.
    start = 1'b1; in_data[0] = 128; in_data[1] = 64;
    cycle();
    start = 1'b0;
    done_cnt_a = 0;
    for (int kk = 1; kk <= 261; kk++) begin
      start = (kk > 4) && ($urandom_range(3) == 0);
      for (int i = 0; i < IN_N; i++) in_data[i] = int'($urandom);
      cycle();
      if (kk == 259) check("a.compute_at_259", bus_a.net_compute, 1);
      if (kk == 2)   check("b.compute_at_2", bus_b.net_compute, 1);
      if (kk == 4)   check("b.done_at_4", bus_b.done, 1);
    end
    check("a.done_at_261", bus_a.done, 1);
    check("a.result_valid_after_done", bus_a.result_valid, 1);
    check("a.net_input0_held", bus_a.net_input[0], 128);
    check("a.net_input1_held", bus_a.net_input[1], 64);
    check("a.done_count", done_cnt_a, 1);
    start = 1'b0;
    cycle();

    // Abort in RUN with the down-counter at 100, then a clean rerun.
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (158) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("a.busy_after_abort", bus_a.busy, 0);
    check("a.result_valid_after_abort", bus_a.result_valid, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (261) cycle();
    check("a.done_after_rerun", bus_a.done, 1);

    // Start and abort together in IDLE.
    repeat (2) cycle();
    start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    check("a.busy_start_with_abort", bus_a.busy, 0);
    check("b.busy_start_with_abort", bus_b.busy, 0);

    // Reset pulse while dut_a sits in SETTLE.
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    do_reset();
    check("a.idle_after_reset", bus_a.busy, 0);

    // Randomized traffic, with one extra reset halfway through.
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(7) == 0);
      abort = ($urandom_range(399) == 0);
      for (int i = 0; i < IN_N; i++) in_data[i] = int'($urandom);
      cycle();
      if (n == 1500) do_reset();
    end
    start = 1'b0; abort = 1'b0;
    repeat (270) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/network_sequencer.md
NETWORK_SEQUENCER -- requirements
Module: network_sequencer

Interface
REQ-001: Parameter INPUT_SIZE, default 2, number of integer network inputs.
REQ-002: Parameter OUTPUT_SIZE, default 1, number of integer network outputs.
REQ-003: Parameter STREAM_LEN, default 256, bitstream window length in cycles; legal range 1..65535.
REQ-004: Parameter SETTLE_LEN, default 2, pipeline fill cycles discarded before the window; legal range 0..255.
REQ-005: clk  input  1  single clock; all state updates on its rising edge.
REQ-006: n_rst  input  1  asynchronous active-low reset.
REQ-007: start  input  1  request one inference; accepted only in IDLE.
REQ-008: abort  input  1  cancel the run in progress.
REQ-009: in_data  input  int[0:INPUT_SIZE-1]  operands sampled on start acceptance.
REQ-010: net_input  output  int[0:INPUT_SIZE-1]  latched operands driven to the network's inputs.
REQ-011: net_n_rst  output  1  registered active-low reset to the network, generators and integrators.
REQ-012: net_compute  output  1  capture strobe to the network integrators.
REQ-013: net_output  input  int[0:OUTPUT_SIZE-1]  network integrator results.
REQ-014: busy  output  1  high in every state except IDLE.
REQ-015: done  output  1  one-cycle pulse on successful completion.
REQ-016: result  output  int[0:OUTPUT_SIZE-1]  captured network result.
REQ-017: result_valid  output  1  result holds a completed inference.

Function
REQ-018: The FSM shall have exactly these states: IDLE, CLEAR, SETTLE, RUN, CAPTURE, LATCH.
REQ-019: In IDLE with start=1 and abort=0, the block shall latch in_data into net_input, clear result_valid, and go to CLEAR on the next edge.
REQ-020: CLEAR shall last exactly 1 cycle with net_n_rst=0; net_n_rst shall be 1 in all other states.
REQ-021: SETTLE shall last exactly SETTLE_LEN cycles; with SETTLE_LEN=0, CLEAR shall go directly to RUN.
REQ-022: RUN shall last exactly STREAM_LEN cycles, counted by a down-counter of width clog2(STREAM_LEN+1) loaded with STREAM_LEN-1 on RUN entry.
REQ-023: CAPTURE shall last 1 cycle with net_compute=1; net_compute shall be 0 in all other states.
REQ-024: LATCH shall last 1 cycle; on its closing edge the block shall copy net_output into result, set result_valid=1, pulse done for the following cycle, and return to IDLE.
REQ-025: Latency from the start-accept edge to the done pulse shall be 1+SETTLE_LEN+STREAM_LEN+2 cycles (261 at defaults).
REQ-026: Once set, result and result_valid shall hold until the next accepted start.
REQ-027: net_input shall remain stable from start acceptance until the next accepted start; in_data changes while busy shall have no effect.
REQ-028: start while busy shall be ignored and shall not be queued.
REQ-029: abort=1 in any non-IDLE state shall return the FSM to IDLE on the next edge, with no done pulse, result_valid=0, and net_compute=0.
REQ-030: abort=1 in the same cycle as start in IDLE shall take priority, and start shall be ignored.
REQ-031: The RUN counter shall not wrap; reaching 0 shall move the FSM to CAPTURE.
REQ-032: done, net_compute and net_n_rst shall be driven from registers (glitch-free).

Reset
REQ-033: n_rst=0 shall asynchronously force state=IDLE, counters=0, busy=0, done=0, net_compute=0, net_n_rst=0, result_valid=0, result=0, net_input=0.
REQ-034: net_n_rst shall go to 1 on the first clk edge after n_rst deasserts.
REQ-035: Reset asserted mid-run shall discard the run and produce no done pulse.

Verification
REQ-036: Reset, then start with in_data={128,64} at defaults -> net_n_rst low for 1 cycle; net_compute high exactly 1 cycle, 259 cycles after acceptance; done high 261 cycles after acceptance; result equals net_output sampled in LATCH; result_valid=1.
REQ-037: Repeated start pulses while busy, with in_data toggling -> exactly one done pulse; net_input stays {128,64}.
REQ-038: abort in RUN at count 100 -> busy falls next cycle; no net_compute; no done; result_valid=0; a new start then completes normally.
REQ-039: STREAM_LEN=1, SETTLE_LEN=0 -> done 4 cycles after acceptance; net_compute high 1 cycle.
REQ-040: n_rst pulsed low mid-SETTLE -> all outputs take their reset values immediately; IDLE after release; no done pulse.
REQ-041: start and abort high together in IDLE -> FSM stays in IDLE; busy=0.
